// File: rtl/spi_slave_device_if.sv
// Bus bundle for spi_slave_device: SPI pins plus the parallel TX/RX word handshake.
interface spi_slave_device_if;
    logic        SCK;
    logic        CSbar;
    logic        MOSI;
    logic        MISO;
    logic [15:0] DATA_MISO;
    logic        LOAD;
    logic        TX_RDY;
    logic [15:0] DATA_MOSI;
    logic        FIN;
    logic        UNDERRUN;
    logic        ABORT;

    modport slave (
        input  SCK, CSbar, MOSI, DATA_MISO, LOAD,
        output MISO, TX_RDY, DATA_MOSI, FIN, UNDERRUN, ABORT
    );

    modport master (
        output SCK, CSbar, MOSI, DATA_MISO, LOAD,
        input  MISO, TX_RDY, DATA_MOSI, FIN, UNDERRUN, ABORT
    );
endinterface

// File: rtl/spi_slave_device.sv
// Mode-0 SPI slave, 16-bit words, oversampled by SYS_CLK, with TX holding register.
// Define SPI_SLAVE_MISO_TRISTATE_EN to float MISO while idle or in reset.
module spi_slave_device (
    input  logic              SYS_CLK,
    input  logic              RSTbar,
    spi_slave_device_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LOAD_WORD, SHIFT} state_t;

    state_t      state_q, state_d;
    logic [2:0]  sck_q, cs_q;        // [1:0] synchronizer, [2] edge-detect delay
    logic [1:0]  mosi_q;
    logic [2:0]  sync_ok_q;
    logic [15:0] tx_q, tx_d;
    logic [15:0] rx_q, rx_d;
    logic [15:0] hold_q, hold_d;
    logic [15:0] dmosi_q, dmosi_d;
    logic        hold_full_q, hold_full_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        reload_q, reload_d;
    logic        wrap_q, wrap_d;
    logic        fin_q, fin_d;
    logic        unr_q, unr_d;
    logic        abort_q, abort_d;
    logic        fetch;
    logic        sck_rise, sck_fall, cs_rise, cs_fall;

    // The sync chain resets to idle levels; a CSbar held low across reset must not
    // look like a falling edge, so falls count only once the chain holds real pin values.
    assign sck_rise = sck_q[1] & ~sck_q[2];
    assign sck_fall = ~sck_q[1] & sck_q[2];
    assign cs_rise  = cs_q[1] & ~cs_q[2];
    assign cs_fall  = ~cs_q[1] & cs_q[2] & sync_ok_q[2];

    always_ff @(posedge SYS_CLK or negedge RSTbar) begin
        if (!RSTbar) begin
            sck_q     <= 3'b000;
            cs_q      <= 3'b111;
            mosi_q    <= 2'b00;
            sync_ok_q <= '0;
        end else begin
            sck_q     <= {sck_q[1:0], bus.SCK};
            cs_q      <= {cs_q[1:0], bus.CSbar};
            mosi_q    <= {mosi_q[0], bus.MOSI};
            sync_ok_q <= {sync_ok_q[1:0], 1'b1};
        end
    end

    always_ff @(posedge SYS_CLK or negedge RSTbar) begin
        if (!RSTbar) begin
            state_q     <= IDLE;
            tx_q        <= '0;
            rx_q        <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            dmosi_q     <= '0;
            cnt_q       <= '0;
            reload_q    <= 1'b0;
            wrap_q      <= 1'b0;
            fin_q       <= 1'b0;
            unr_q       <= 1'b0;
            abort_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            dmosi_q     <= dmosi_d;
            cnt_q       <= cnt_d;
            reload_q    <= reload_d;
            wrap_q      <= wrap_d;
            fin_q       <= fin_d;
            unr_q       <= unr_d;
            abort_q     <= abort_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        tx_d        = tx_q;
        rx_d        = rx_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        dmosi_d     = dmosi_q;
        cnt_d       = cnt_q;
        reload_d    = reload_q;
        wrap_d      = 1'b0;
        fin_d       = 1'b0;
        unr_d       = 1'b0;
        abort_d     = 1'b0;
        fetch       = 1'b0;

        // A completed word is published one cycle after the wrap, even if CSbar rises meanwhile.
        if (wrap_q) begin
            dmosi_d = rx_q;
            fin_d   = 1'b1;
        end

        if (cs_rise) begin
            state_d  = IDLE;
            abort_d  = (state_q != IDLE) && (cnt_q != '0);
            cnt_d    = '0;
            reload_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cs_fall) state_d = LOAD_WORD;
                end
                LOAD_WORD: begin
                    fetch    = 1'b1;
                    cnt_d    = '0;
                    reload_d = 1'b0;
                    state_d  = SHIFT;
                end
                SHIFT: begin
                    if (sck_rise) begin
                        rx_d  = {rx_q[14:0], mosi_q[1]};
                        cnt_d = cnt_q + 4'd1;
                        if (cnt_q == 4'd15) begin
                            wrap_d   = 1'b1;
                            reload_d = 1'b1;
                        end
                    end
                    if (sck_fall) begin
                        if (reload_q) begin
                            fetch    = 1'b1;
                            reload_d = 1'b0;
                        end else begin
                            tx_d = {tx_q[14:0], 1'b0};
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // Fetch order: holding register, then a same-cycle LOAD bypass, else underrun.
        if (fetch) begin
            if (hold_full_q) begin
                tx_d        = hold_q;
                hold_full_d = 1'b0;
            end else if (bus.LOAD) begin
                tx_d = bus.DATA_MISO;
            end else begin
                tx_d  = '0;
                unr_d = 1'b1;
            end
        end else if (bus.LOAD && !hold_full_q) begin
            hold_d      = bus.DATA_MISO;
            hold_full_d = 1'b1;
        end
    end

`ifdef SPI_SLAVE_MISO_TRISTATE_EN
    assign bus.MISO = (state_q != IDLE) ? tx_q[15] : 1'bz;
`else
    assign bus.MISO = (state_q != IDLE) ? tx_q[15] : 1'b0;
`endif

    assign bus.TX_RDY    = ~hold_full_q;
    assign bus.DATA_MOSI = dmosi_q;
    assign bus.FIN       = fin_q;
    assign bus.UNDERRUN  = unr_q;
    assign bus.ABORT     = abort_q;
endmodule

// File: tb/tb_spi_slave_device.sv
// Scoreboard bench for spi_slave_device: stimulus queues expectations, monitors pop and compare.
module tb_spi_slave_device;
    typedef struct {
        logic [15:0] word;
        int          cyc;
    } fin_t;

`ifdef SPI_SLAVE_MISO_TRISTATE_EN
    localparam logic MISO_IDLE = 1'bz;
`else
    localparam logic MISO_IDLE = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    fin_t        exp_fin[$];
    logic [15:0] exp_miso[$];
    int          exp_unr[$];
    int          exp_abort[$];

    spi_slave_device_if bus();

    spi_slave_device dut (
        .SYS_CLK (clk),
        .RSTbar  (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [15:0] w);
        bus.LOAD      = 1'b1;
        bus.DATA_MISO = w;
        tick();
        bus.LOAD      = 1'b0;
    endtask

    // end_mode 0: last SCK fall coincides with CSbar rise; 1: last fall coincides with reset.
    task automatic spi_frame(input logic [31:0] bits, input int nbits, input int end_mode,
                             input bit lw_load, input logic [15:0] lw_word,
                             input bit b2b, input logic [15:0] b2b_word);
        fin_t        f;
        logic [31:0] sh;
        int          n;
        bus.CSbar = 1'b0;
        bus.MOSI  = bits[nbits-1];
        if (lw_load) begin
            repeat (3) tick();
            bus.LOAD      = 1'b1;
            bus.DATA_MISO = lw_word;
            tick();
            bus.LOAD      = 1'b0;
            chk("tx_rdy_after_bypass", 32'(bus.TX_RDY), 32'd1);
        end else begin
            repeat (4) tick();
        end
        for (int i = 0; i < nbits; i++) begin
            bus.SCK = 1'b1;
            if (i % 16 == 15) begin
                sh     = bits >> (nbits - 1 - i);
                f.word = sh[15:0];
                f.cyc  = cyc + 4;
                exp_fin.push_back(f);
            end
            repeat (2) tick();
            if (b2b && i == 15) begin
                n = 0;
                while (!bus.FIN && n < 10) begin
                    tick();
                    n++;
                end
                chk("b2b_fin_seen", 32'(bus.FIN), 32'd1);
                load_word(b2b_word);
            end
            if (i == nbits - 1) begin
                bus.SCK = 1'b0;
                if (end_mode == 1) rst_n = 1'b0;
                else               bus.CSbar = 1'b1;
            end else begin
                bus.SCK  = 1'b0;
                bus.MOSI = bits[nbits-2-i];
            end
            repeat (2) tick();
        end
    endtask

    // Pulse monitor: FIN with data and cycle, UNDERRUN, ABORT.
    always @(negedge clk) begin
        fin_t e;
        if (rst_n === 1'b1) begin
            if (bus.FIN) begin
                if (exp_fin.size() == 0) begin
                    chk("unexpected_fin", 32'(bus.FIN), 32'd0);
                end else begin
                    e = exp_fin.pop_front();
                    chk("fin_data", 32'(bus.DATA_MOSI), 32'(e.word));
                    chk("fin_cycle", 32'(cyc), 32'(e.cyc));
                end
            end
            if (bus.UNDERRUN) begin
                if (exp_unr.size() == 0) chk("unexpected_underrun", 32'(bus.UNDERRUN), 32'd0);
                else void'(exp_unr.pop_front());
            end
            if (bus.ABORT) begin
                if (exp_abort.size() == 0) chk("unexpected_abort", 32'(bus.ABORT), 32'd0);
                else void'(exp_abort.pop_front());
            end
        end
    end

    // MISO monitor: the master samples on each SCK fall; 16 samples form a word.
    initial begin
        logic        sck_prev;
        logic        cs_prev;
        logic [15:0] acc;
        logic [15:0] w;
        int          bitcnt;
        sck_prev = 1'b0;
        cs_prev  = 1'b1;
        bitcnt   = 0;
        acc      = '0;
        forever begin
            @(bus.SCK or bus.CSbar);
            if (cs_prev === 1'b1 && bus.CSbar === 1'b0) bitcnt = 0;
            if (sck_prev === 1'b1 && bus.SCK === 1'b0 && cs_prev === 1'b0) begin
                acc = {acc[14:0], bus.MISO};
                bitcnt++;
                if (bitcnt == 16) begin
                    bitcnt = 0;
                    if (exp_miso.size() == 0) begin
                        chk("unexpected_miso_word", 32'(acc), 32'hFFFF_FFFF);
                    end else begin
                        w = exp_miso.pop_front();
                        chk("miso_word", 32'(acc), 32'(w));
                    end
                end
            end
            sck_prev = bus.SCK;
            cs_prev  = bus.CSbar;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        rst_n         = 1'b0;
        bus.SCK       = 1'b0;
        bus.CSbar     = 1'b1;
        bus.MOSI      = 1'b0;
        bus.LOAD      = 1'b0;
        bus.DATA_MISO = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_data_mosi", 32'(bus.DATA_MOSI), 32'h0);
        chk("rst_tx_rdy", 32'(bus.TX_RDY), 32'd1);
        chk("rst_fin", 32'(bus.FIN), 32'd0);
        chk("rst_underrun", 32'(bus.UNDERRUN), 32'd0);
        chk("rst_abort", 32'(bus.ABORT), 32'd0);
        chk("rst_miso", 32'(bus.MISO), 32'(MISO_IDLE));
        rst_n = 1'b1;
        repeat (4) tick();

        // Basic word: transmit A5C3, receive 1234
        load_word(16'hA5C3);
        chk("tx_rdy_after_load", 32'(bus.TX_RDY), 32'd0);
        exp_miso.push_back(16'hA5C3);
        spi_frame(32'h0000_1234, 16, 0, 1'b0, '0, 1'b0, '0);
        repeat (8) tick();
        chk("data_mosi_1234", 32'(bus.DATA_MOSI), 32'h1234);
        chk("tx_rdy_after_frame", 32'(bus.TX_RDY), 32'd1);
        chk("miso_idle", 32'(bus.MISO), 32'(MISO_IDLE));

        // SCK activity while deselected is ignored
        repeat (5) begin
            bus.SCK = 1'b1;
            repeat (2) tick();
            bus.SCK = 1'b0;
            repeat (2) tick();
        end
        chk("idle_sck_data_mosi", 32'(bus.DATA_MOSI), 32'h1234);

        // Underrun: no LOAD before frame
        exp_unr.push_back(1);
        exp_miso.push_back(16'h0000);
        spi_frame(32'h0000_BEEF, 16, 0, 1'b0, '0, 1'b0, '0);
        repeat (8) tick();
        chk("data_mosi_beef", 32'(bus.DATA_MOSI), 32'hBEEF);

        // Abort after 9 bits, then a clean frame
        load_word(16'h5A5A);
        exp_abort.push_back(1);
        spi_frame(32'h0000_FFFF, 9, 0, 1'b0, '0, 1'b0, '0);
        repeat (8) tick();
        chk("abort_data_mosi_kept", 32'(bus.DATA_MOSI), 32'hBEEF);
        load_word(16'h3C3C);
        exp_miso.push_back(16'h3C3C);
        spi_frame(32'h0000_C0DE, 16, 0, 1'b0, '0, 1'b0, '0);
        repeat (8) tick();
        chk("data_mosi_c0de", 32'(bus.DATA_MOSI), 32'hC0DE);

        // Back-to-back: 32 clocks under one CSbar
        load_word(16'h0F0F);
        exp_miso.push_back(16'h0F0F);
        exp_miso.push_back(16'hF0F0);
        spi_frame(32'h1357_9BDF, 32, 0, 1'b0, '0, 1'b1, 16'hF0F0);
        repeat (8) tick();
        chk("data_mosi_9bdf", 32'(bus.DATA_MOSI), 32'h9BDF);
        chk("tx_rdy_after_b2b", 32'(bus.TX_RDY), 32'd1);

        // LOAD bypass in the LOAD_WORD cycle, then an ignored second LOAD
        exp_miso.push_back(16'h6789);
        spi_frame(32'h0000_A0A0, 16, 0, 1'b1, 16'h6789, 1'b0, '0);
        repeat (8) tick();
        chk("data_mosi_a0a0", 32'(bus.DATA_MOSI), 32'hA0A0);
        load_word(16'h1111);
        chk("tx_rdy_full", 32'(bus.TX_RDY), 32'd0);
        load_word(16'h2222);
        chk("tx_rdy_still_full", 32'(bus.TX_RDY), 32'd0);
        exp_miso.push_back(16'h1111);
        spi_frame(32'h0000_4242, 16, 0, 1'b0, '0, 1'b0, '0);
        repeat (8) tick();
        chk("data_mosi_4242", 32'(bus.DATA_MOSI), 32'h4242);

        // Reset after bit 7 of a word
        load_word(16'h7777);
        spi_frame(32'h0000_00AA, 7, 1, 1'b0, '0, 1'b0, '0);
        chk("midrst_data_mosi", 32'(bus.DATA_MOSI), 32'h0);
        chk("midrst_tx_rdy", 32'(bus.TX_RDY), 32'd1);
        chk("midrst_fin", 32'(bus.FIN), 32'd0);
        chk("midrst_abort", 32'(bus.ABORT), 32'd0);
        chk("midrst_underrun", 32'(bus.UNDERRUN), 32'd0);
        chk("midrst_miso", 32'(bus.MISO), 32'(MISO_IDLE));
        rst_n = 1'b1;
        repeat (10) tick();
        chk("postrst_miso_idle", 32'(bus.MISO), 32'(MISO_IDLE));
        bus.CSbar = 1'b1;
        repeat (8) tick();
        chk("postrst_data_mosi", 32'(bus.DATA_MOSI), 32'h0);
        exp_unr.push_back(1);
        exp_miso.push_back(16'h0000);
        spi_frame(32'h0000_8001, 16, 0, 1'b0, '0, 1'b0, '0);
        repeat (8) tick();
        chk("data_mosi_8001", 32'(bus.DATA_MOSI), 32'h8001);

        repeat (4) tick();
        chk("pending_fin", 32'(exp_fin.size()), 32'd0);
        chk("pending_miso", 32'(exp_miso.size()), 32'd0);
        chk("pending_underrun", 32'(exp_unr.size()), 32'd0);
        chk("pending_abort", 32'(exp_abort.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/spi_slave_device.md
SPI_SLAVE_DEVICE -- requirements
Module: spi_slave_device

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset; all state SHALL be clocked on the rising edge of SYS_CLK.
REQ-002 SYS_CLK  input  1  system clock; SCK frequency ≤ SYS_CLK/4.
REQ-003 RSTbar  input  1  asynchronous active-low reset.
REQ-004 SCK  input  1  SPI clock from the master; idles low (mode 0).
REQ-005 CSbar  input  1  active-low frame select from the master.
REQ-006 MOSI  input  1  serial data from the master, MSB first.
REQ-007 MISO  output  1  serial data to the master, MSB first.
REQ-008 DATA_MISO  input  16  next word to transmit.
REQ-009 LOAD  input  1  single-cycle strobe that writes DATA_MISO into the TX holding register.
REQ-010 TX_RDY  output  1  high while the TX holding register is empty.
REQ-011 DATA_MOSI  output  16  last complete received word; held until the next word completes.
REQ-012 FIN  output  1  single-cycle pulse marking a new DATA_MOSI.
REQ-013 UNDERRUN  output  1  single-cycle pulse when a word starts with an empty holding register.
REQ-014 ABORT  output  1  single-cycle pulse when CSbar rises mid-word.

Function
REQ-015 SCK, CSbar and MOSI SHALL each pass through a 2-flop synchronizer; edge detection SHALL compare the second synchronizer stage against a third delay register.
REQ-016 The state machine SHALL have three states: IDLE, LOAD_WORD and SHIFT.
REQ-017 IDLE→LOAD_WORD SHALL occur on a synchronized CSbar falling edge.
REQ-018 LOAD_WORD SHALL last one cycle: it copies the holding register into the TX shift register, clears the bit counter, then goes to SHIFT.
REQ-019 Any state SHALL go to IDLE on a synchronized CSbar rising edge; a rising CSbar has priority over every SCK edge in the same cycle.
REQ-020 In SHIFT, on a synchronized SCK rising edge, the block SHALL shift the synchronized MOSI into the RX shift register LSB and increment the 4-bit counter.
REQ-021 In SHIFT, on a synchronized SCK falling edge, the TX shift register SHALL shift left and MISO SHALL present the new MSB.
REQ-022 MISO SHALL present TX bit 15 from the cycle after LOAD_WORD; the master SHALL allow ≥ 4 SYS_CLK cycles from CSbar falling to the first SCK rise.
REQ-023 When the counter wraps 15→0, DATA_MOSI SHALL be updated and FIN SHALL pulse exactly 4 SYS_CLK cycles after the 16th SCK rising edge at the pin.
REQ-024 With CSbar still low after a wrap, the next SCK falling edge SHALL reload the TX shift register from the holding register (continuous back-to-back words), not shift it.
REQ-025 If the holding register is empty at LOAD_WORD or at a reload, the TX shift register SHALL load 16'h0000 and UNDERRUN SHALL pulse.
REQ-026 A LOAD while TX_RDY=1 SHALL fill the holding register and clear TX_RDY on the next cycle.
REQ-027 A LOAD while TX_RDY=0 SHALL be ignored and SHALL NOT overwrite the holding register.
REQ-028 A LOAD in the same cycle as LOAD_WORD or a reload with an empty holding register SHALL bypass straight into the TX shift register; no UNDERRUN SHALL occur and TX_RDY SHALL stay 1.
REQ-029 A transfer out of the holding register SHALL set TX_RDY=1 on the next cycle.
REQ-030 CSbar rising with a counter value of 1..15 SHALL discard the partial RX word, leave DATA_MOSI unchanged, pulse ABORT and suppress FIN.
REQ-031 CSbar rising with a counter value of 0 SHALL pulse no ABORT.
REQ-032 SCK edges while in IDLE SHALL be ignored.

Reset
REQ-033 While RSTbar=0, the block SHALL hold: state=IDLE, shift registers and counter=0, holding register empty, TX_RDY=1, DATA_MOSI=16'h0000, FIN=UNDERRUN=ABORT=0, synchronizers=idle values (SCK 0, CSbar 1, MOSI 0), MISO per REQ-035.
REQ-034 Reset asserted mid-word SHALL abandon the word with no FIN or ABORT pulse; after release, the block SHALL wait for a fresh CSbar falling edge.

Configuration
REQ-035 With macro SPI_SLAVE_MISO_TRISTATE_EN defined, MISO SHALL be 1'bz whenever the block is in IDLE or reset; undefined, MISO SHALL drive 1'b0 in those conditions; behaviour in LOAD_WORD/SHIFT SHALL be identical in both builds.

Verification
REQ-036 LOAD 16'hA5C3, then a 16-bit frame with MOSI=16'h1234 at SCK=SYS_CLK/4 -> MISO bits equal A5C3 MSB-first; DATA_MOSI=16'h1234; one FIN, 4 cycles after the 16th SCK rise; TX_RDY=1 afterwards.
REQ-037 Frame with no LOAD -> UNDERRUN pulses once; MISO is all zeros; FIN still pulses with the received word.
REQ-038 CSbar raised after 9 bits -> ABORT pulses once, no FIN, DATA_MOSI unchanged; the next full frame is received correctly.
REQ-039 32 SCK clocks under a single CSbar, with LOAD 16'h0F0F before the frame and LOAD 16'hF0F0 after the first FIN -> two FINs; MISO carries 0F0F then F0F0.
REQ-040 LOAD in the LOAD_WORD cycle with an empty holding register -> word transmitted, no UNDERRUN, TX_RDY stays 1; a second LOAD while TX_RDY=0 -> ignored.
REQ-041 RSTbar pulsed low after bit 7 -> all outputs at reset values, no FIN/ABORT; check MISO=z with SPI_SLAVE_MISO_TRISTATE_EN and 0 without it.
